// File: rtl/encode_packet.sv
// Transmit-side DFX packetizer: slices one {addr, data} word into NUMBER_PACKET Aurora words,
// each tagged with the source router ID and its packet index, for the receive-side decoder.
module encode_packet #(
    parameter int          DATA_WIDTH        = 1024,
    parameter int          ADDR_WIDTH        = 10,
    parameter int          DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int          AURORA_DATA_WIDTH = 64,
    parameter int          NUMBER_PACKET     = 19,
    parameter logic [1:0]  ROUTER_ID         = 2'b00
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_dfx_data,
    input  logic [DATA_DFX_WIDTH-1:0]     data_dfx_send,
    output logic                          ready_dfx,
    output logic [AURORA_DATA_WIDTH-1:0]  tx_tdata,
    output logic                          tx_tvalid,
    input  logic                          tx_tready,
    output logic                          busy,
    output logic                          encode_done
);

    // Header takes bits [8:0]; the remainder of each Aurora word is payload.
    localparam int SLICE_WIDTH = AURORA_DATA_WIDTH - 9;
    localparam int PAD_WIDTH   = NUMBER_PACKET * SLICE_WIDTH;
    localparam int CNT_W       = $clog2(NUMBER_PACKET);
    localparam logic [CNT_W-1:0] LAST_PKT = CNT_W'(NUMBER_PACKET - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                state;
    logic [CNT_W-1:0]          pkt_cnt;
    logic [CNT_W-1:0]          cnt_next;
    logic [DATA_DFX_WIDTH-1:0] shadow;

    // Zero-padding the input to a whole number of slices makes the last, partial
    // word fall out of the same indexing as the full ones.
    function automatic logic [AURORA_DATA_WIDTH-1:0] make_word(
        input logic [DATA_DFX_WIDTH-1:0] d,
        input logic [CNT_W-1:0]          idx
    );
        logic [PAD_WIDTH-1:0] padded;
        padded    = PAD_WIDTH'(d);
        make_word = {padded[int'(idx)*SLICE_WIDTH +: SLICE_WIDTH], 2'b00, 5'(idx), ROUTER_ID};
    endfunction

    assign cnt_next = pkt_cnt + 1'b1;
    assign busy     = (state != S_IDLE);

    // Handshakes: an input word transfers on a rising edge where valid_dfx_data && ready_dfx;
    // an Aurora word transfers where tx_tvalid && tx_tready. Once raised, tx_tvalid and tx_tdata
    // hold until the transfer, and tx_tvalid stays high for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pkt_cnt     <= '0;
            shadow      <= '0;
            ready_dfx   <= 1'b0;
            tx_tdata    <= '0;
            tx_tvalid   <= 1'b0;
            encode_done <= 1'b0;
        end else begin
            encode_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_dfx_data && ready_dfx) begin
                        shadow    <= data_dfx_send;
                        pkt_cnt   <= '0;
                        ready_dfx <= 1'b0;
                        tx_tdata  <= make_word(data_dfx_send, {CNT_W{1'b0}});
                        tx_tvalid <= 1'b1;
                        state     <= S_SEND;
                    end else begin
                        ready_dfx <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (tx_tvalid && tx_tready) begin
                        if (pkt_cnt == LAST_PKT) begin
                            tx_tvalid   <= 1'b0;
                            encode_done <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            pkt_cnt  <= cnt_next;
                            tx_tdata <= make_word(shadow, cnt_next);
                        end
                    end
                end
                S_DONE: begin
                    ready_dfx <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    ready_dfx <= 1'b0;
                    tx_tvalid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encode_packet.sv
// Directed bench for encode_packet: reset, frame format, backpressure, input hold,
// mid-frame reset and reassembly of the payload from the emitted words.
module tb_encode_packet;

    localparam int         DW  = 1034;
    localparam logic [1:0] RID = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_dfx_data;
    logic [DW-1:0] data_dfx_send;
    logic          ready_dfx;
    logic [63:0]   tx_tdata;
    logic          tx_tvalid;
    logic          tx_tready;
    logic          busy;
    logic          encode_done;

    int checks = 0;
    int errors = 0;
    logic [63:0] words_seen [19];

    always #5 clk = ~clk;

    encode_packet #(.ROUTER_ID(RID)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_dfx_data (valid_dfx_data),
        .data_dfx_send  (data_dfx_send),
        .ready_dfx      (ready_dfx),
        .tx_tdata       (tx_tdata),
        .tx_tvalid      (tx_tvalid),
        .tx_tready      (tx_tready),
        .busy           (busy),
        .encode_done    (encode_done)
    );

    function automatic logic [63:0] exp_word(input logic [DW-1:0] d, input int idx);
        logic [63:0] w;
        int src;
        w      = '0;
        w[1:0] = RID;
        w[6:2] = 5'(idx);
        for (int b = 0; b < 55; b++) begin
            src = idx * 55 + b;
            if (src < DW) w[9+b] = d[src];
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int b = 0; b < DW; b++) r[b] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got low128 %h expected low128 %h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    // stall_len < 0 selects random tready; abort_word >= 0 pulses reset when that word is pending.
    task automatic run_frame(input logic [DW-1:0] d, input logic [DW-1:0] next_d, input bit hold,
                             input int stall_word, input int stall_len, input int abort_word,
                             output int done_cyc);
        int idx, cyc, stalls, waited, src;
        logic [DW-1:0] rebuilt;
        done_cyc       = -1;
        valid_dfx_data = 1'b1;
        data_dfx_send  = d;
        tx_tready      = 1'b1;
        waited         = 0;
        while (ready_dfx !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check64("accept_ready", 64'(ready_dfx), 64'd1);
        if (ready_dfx !== 1'b1) begin
            valid_dfx_data = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cyc    = 1;
        idx    = 0;
        stalls = 0;
        if (hold) data_dfx_send = next_d;
        else      valid_dfx_data = 1'b0;
        while (idx < 19 && cyc < 400) begin
            if (idx == abort_word) begin
                tx_tready      = 1'b0;
                valid_dfx_data = 1'b0;
                rst_n          = 1'b0;
                #1;
                check64("abort_tvalid", 64'(tx_tvalid), 64'd0);
                check64("abort_tdata", tx_tdata, 64'd0);
                check64("abort_busy", 64'(busy), 64'd0);
                check64("abort_ready", 64'(ready_dfx), 64'd0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check64("abort_ready_after", 64'(ready_dfx), 64'd1);
                return;
            end
            check64("word_tvalid", 64'(tx_tvalid), 64'd1);
            check64($sformatf("word%0d_tdata", idx), tx_tdata, exp_word(d, idx));
            check64("word_ready", 64'(ready_dfx), 64'd0);
            check64("word_done", 64'(encode_done), 64'd0);
            words_seen[idx] = tx_tdata;
            if (stall_len < 0) tx_tready = 1'($urandom_range(0, 1));
            else if (idx == stall_word && stalls < stall_len) tx_tready = 1'b0;
            else tx_tready = 1'b1;
            if (!tx_tready) stalls++;
            @(posedge clk);
            if (tx_tready) idx++;
            @(negedge clk);
            cyc++;
        end
        check64("frame_complete", 64'(idx), 64'd19);
        check64("done_pulse", 64'(encode_done), 64'd1);
        check64("done_tvalid", 64'(tx_tvalid), 64'd0);
        check64("done_busy", 64'(busy), 64'd1);
        check64("done_ready", 64'(ready_dfx), 64'd0);
        check64("done_cycle", 64'(cyc), 64'(20 + stalls));
        done_cyc = cyc;
        @(negedge clk);
        check64("idle_done", 64'(encode_done), 64'd0);
        check64("idle_ready", 64'(ready_dfx), 64'd1);
        check64("idle_busy", 64'(busy), 64'd0);
        rebuilt = '0;
        for (int i = 0; i < 19; i++) begin
            for (int b = 0; b < 55; b++) begin
                src = i * 55 + b;
                if (src < DW) rebuilt[src] = words_seen[i][9+b];
            end
        end
        check_wide("reassembled", rebuilt, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d2, da, db;
        int done;
        rst_n          = 1'b0;
        valid_dfx_data = 1'b0;
        data_dfx_send  = '0;
        tx_tready      = 1'b0;

        repeat (5) @(negedge clk);
        check64("rst_tdata", tx_tdata, 64'd0);
        check64("rst_tvalid", 64'(tx_tvalid), 64'd0);
        check64("rst_ready", 64'(ready_dfx), 64'd0);
        check64("rst_busy", 64'(busy), 64'd0);
        check64("rst_done", 64'(encode_done), 64'd0);
        rst_n = 1'b1;
        #1;
        check64("release_ready_same", 64'(ready_dfx), 64'd0);
        @(negedge clk);
        check64("release_ready_next", 64'(ready_dfx), 64'd1);

        d2    = '0;
        d2[0] = 1'b1;
        for (int b = 990; b < DW; b++) d2[b] = 1'b1;
        run_frame(d2, '0, 1'b0, -1, 0, -1, done);
        check64("fmt_word0", words_seen[0], 64'h0000_0000_0000_0202);
        check64("fmt_word18", words_seen[18], 64'h001F_FFFF_FFFF_FE4A);
        check64("fmt_done_cycle", 64'(done), 64'd20);

        da = rand_word();
        run_frame(da, '0, 1'b0, 7, 5, -1, done);
        check64("bp_done_cycle", 64'(done), 64'd25);

        da = rand_word();
        db = rand_word();
        run_frame(da, db, 1'b1, -1, 0, -1, done);
        check64("hold_first_done", 64'(done), 64'd20);
        run_frame(db, '0, 1'b0, -1, 0, -1, done);
        check64("hold_second_word0", words_seen[0], exp_word(db, 0));
        check64("hold_second_done", 64'(done), 64'd20);

        da = rand_word();
        run_frame(da, '0, 1'b0, -1, 0, 10, done);
        db = rand_word();
        run_frame(db, '0, 1'b0, -1, 0, -1, done);
        check64("post_abort_word0", words_seen[0], exp_word(db, 0));

        for (int f = 0; f < 6; f++) begin
            da = rand_word();
            run_frame(da, '0, 1'b0, -1, -1, -1, done);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
